tmr_vote_monitor: RTL and testbench
===================================

TMR_VOTE_MONITOR -- requirements
Module: tmr_vote_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of each redundant channel.
REQ-002 The block SHALL have parameter FAULT_LIMIT, default 4, giving the consecutive-mismatch count that excludes a channel.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the width of each total-mismatch counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  channels a/b/c carry one sample set.
REQ-007 in_ready  output  1  block accepts the sample set this cycle.
REQ-008 a, b, c  input  WIDTH each  redundant channel samples.
REQ-009 clear_faults  input  1  single-cycle pulse; re-admits the excluded channel and zeroes all counters.
REQ-010 out_valid  output  1  vote holds a result.
REQ-011 out_ready  input  1  downstream consumes the result.
REQ-012 vote  output  WIDTH  voted data.
REQ-013 out_err  output  1  the result is not trustworthy (duplex disagreement).
REQ-014 excluded  output  3  one-hot excluded channel; bit0=a, bit1=b, bit2=c; all-zero in TRIPLE.
REQ-015 mis_cnt_a, mis_cnt_b, mis_cnt_c  output  CNT_W each  saturating total-mismatch counts.

Function
REQ-016 A transfer SHALL occur when in_valid && in_ready; in_ready = !out_valid || out_ready (single output register, no combinational path from in_valid to out_valid).
REQ-017 The accepted result SHALL appear on vote/out_err/out_valid exactly one cycle after the transfer and hold stable until out_valid && out_ready.
REQ-018 In mode TRIPLE, vote SHALL be the bitwise majority (a&b | a&c | b&c), and out_err SHALL be 0.
REQ-019 In mode TRIPLE, a channel SHALL mismatch on a transfer when any of its bits differs from vote.
REQ-020 Each channel SHALL keep a consecutive-mismatch counter: +1 on a mismatching transfer, cleared on a matching transfer, unchanged without a transfer.
REQ-021 The channel whose counter reaches FAULT_LIMIT SHALL be excluded, and the mode SHALL move TRIPLE->DUPLEX in the cycle after that transfer.
REQ-022 When two or more channels reach FAULT_LIMIT on the same transfer, only the lowest-index channel SHALL be excluded, and the others' consecutive counters SHALL clear to 0.
REQ-023 In mode DUPLEX, vote SHALL equal the lowest-index non-excluded channel, and out_err SHALL be 1 when the two remaining channels differ in any bit.
REQ-024 In mode DUPLEX, the consecutive counters SHALL freeze and no further exclusion SHALL occur; the only modes are TRIPLE and DUPLEX.
REQ-025 Each total-mismatch counter SHALL increment on every mismatching transfer in TRIPLE and saturate at 2^CNT_W-1.
REQ-026 In DUPLEX, a disagreeing transfer SHALL increment mis_cnt of both remaining channels, saturating.
REQ-027 clear_faults SHALL force TRIPLE mode and zero all counters and excluded on the next edge, overriding any counter or exclusion update from a same-cycle transfer.
REQ-028 A transfer that coincides with clear_faults SHALL still be voted using the mode that was current at the time of the transfer.
REQ-029 clear_faults SHALL NOT affect the output register or the handshake.

Reset
REQ-030 While rst_n=0, the block SHALL hold out_valid=0, vote=0, out_err=0, excluded=3'b000, all counters=0, mode=TRIPLE, and in_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard any pending result immediately, without waiting for a clock edge.

Structure
REQ-032 Package tmr_pkg SHALL hold the mode enum (TRIPLE, DUPLEX) and the channel index constants CH_A=0, CH_B=1, CH_C=2.
REQ-033 The bitwise 3-input majority SHALL be a combinational sub-module majority_vote3 (parameter WIDTH), instantiated once.

Verification (WIDTH=8, FAULT_LIMIT=4, CNT_W=8)
REQ-034 Stimulus a=b=c=8'h5A, one transfer -> vote=8'h5A, out_err=0, out_valid one cycle later, all counters 0.
REQ-035 Stimulus: 4 consecutive transfers with a=b=8'h0F, c=8'hFF -> vote=8'h0F each time, mis_cnt_c=4, excluded=3'b100 after the 4th; then a=8'h01, b=8'h02 -> vote=8'h01, out_err=1, mis_cnt_a=mis_cnt_b=1.
REQ-036 Stimulus: bit0 of a and bit1 of b each flipped for 4 transfers (c correct) -> excluded=3'b001, b consecutive counter 0, mis_cnt_b=4.
REQ-037 Stimulus: out_ready held low with a result pending -> in_ready=0, vote stable; then out_ready=1 -> a back-to-back transfer completes every cycle.
REQ-038 Stimulus: clear_faults pulsed in DUPLEX together with a transfer -> that result voted in DUPLEX, then excluded=0, counters 0, next transfer voted by majority.
REQ-039 Stimulus: rst_n dropped asynchronously while out_valid=1 -> out_valid=0 and counters 0 before the next clock edge.

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared types for the triple-modular-redundancy vote monitor: operating modes and channel indices.
package tmr_pkg;

  typedef enum logic {
    TRIPLE = 1'b0,
    DUPLEX = 1'b1
  } mode_e;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;

endpackage

// File: rtl/majority_vote3.sv
// Bitwise 2-of-3 majority over three equal-width words; purely combinational.
module majority_vote3 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] maj
);

  assign maj = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/tmr_vote_monitor.sv
// TMR voter with fault exclusion (TRIPLE -> DUPLEX); result registered, valid one cycle after transfer.
// Single output register: in_ready drops only while a result is held and out_ready is low.
module tmr_vote_monitor
  import tmr_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int FAULT_LIMIT = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             clear_faults,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] vote,
  output logic             out_err,
  output logic [2:0]       excluded,
  output logic [CNT_W-1:0] mis_cnt_a,
  output logic [CNT_W-1:0] mis_cnt_b,
  output logic [CNT_W-1:0] mis_cnt_c
);

  localparam int CONS_W = $clog2(FAULT_LIMIT + 1);

  mode_e             mode_q, mode_d;
  logic [2:0]        excluded_q, excluded_d;
  logic [CONS_W-1:0] cons_q [3];
  logic [CONS_W-1:0] cons_d [3];
  logic [CNT_W-1:0]  mis_q  [3];
  logic [CNT_W-1:0]  mis_d  [3];
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  vote_q, vote_d;
  logic              out_err_q, out_err_d;

  logic [WIDTH-1:0]  maj;
  logic [WIDTH-1:0]  ch [3];
  logic [WIDTH-1:0]  res_vote;
  logic [WIDTH-1:0]  partner;
  logic              res_err;
  logic [2:0]        hit;
  logic              xfer;

  majority_vote3 #(.WIDTH(WIDTH)) u_maj (
    .a  (a),
    .b  (b),
    .c  (c),
    .maj(maj)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    ch[CH_A]    = a;
    ch[CH_B]    = b;
    ch[CH_C]    = c;
    mode_d      = mode_q;
    excluded_d  = excluded_q;
    cons_d      = cons_q;
    mis_d       = mis_q;
    out_valid_d = out_valid_q;
    vote_d      = vote_q;
    out_err_d   = out_err_q;
    res_vote    = maj;
    res_err     = 1'b0;
    partner     = '0;
    hit         = '0;

    if (mode_q == DUPLEX) begin
      // Vote follows the lower surviving channel; the other one is only a cross-check.
      if (excluded_q[CH_A]) begin
        res_vote = b;
        partner  = c;
      end else begin
        res_vote = a;
        partner  = excluded_q[CH_B] ? c : b;
      end
      res_err = (res_vote != partner);
    end

    if (xfer) begin
      out_valid_d = 1'b1;
      vote_d      = res_vote;
      out_err_d   = res_err;
      if (mode_q == TRIPLE) begin
        for (int i = 0; i < 3; i++) begin
          if (ch[i] != maj) begin
            cons_d[i] = cons_q[i] + 1'b1;
            hit[i]    = (cons_q[i] == CONS_W'(FAULT_LIMIT - 1));
            if (mis_q[i] != {CNT_W{1'b1}}) mis_d[i] = mis_q[i] + 1'b1;
          end else begin
            cons_d[i] = '0;
          end
        end
        if (|hit) begin
          mode_d     = DUPLEX;
          excluded_d = hit & (~hit + 3'd1);
          for (int i = 0; i < 3; i++) begin
            if (hit[i] && !excluded_d[i]) cons_d[i] = '0;
          end
        end
      end else if (res_err) begin
        for (int i = 0; i < 3; i++) begin
          if (!excluded_q[i] && (mis_q[i] != {CNT_W{1'b1}})) mis_d[i] = mis_q[i] + 1'b1;
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Fault bookkeeping is reset last so it beats any same-cycle update; the result path is untouched.
    if (clear_faults) begin
      mode_d     = TRIPLE;
      excluded_d = '0;
      for (int i = 0; i < 3; i++) begin
        cons_d[i] = '0;
        mis_d[i]  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= TRIPLE;
      excluded_q  <= '0;
      cons_q      <= '{default: '0};
      mis_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      vote_q      <= '0;
      out_err_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      excluded_q  <= excluded_d;
      cons_q      <= cons_d;
      mis_q       <= mis_d;
      out_valid_q <= out_valid_d;
      vote_q      <= vote_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign vote      = vote_q;
  assign out_err   = out_err_q;
  assign excluded  = excluded_q;
  assign mis_cnt_a = mis_q[CH_A];
  assign mis_cnt_b = mis_q[CH_B];
  assign mis_cnt_c = mis_q[CH_C];

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Directed bench for tmr_vote_monitor: vector table plus hand-written handshake/reset sequences.
module tb_tmr_vote_monitor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b, c;
  logic       clear_faults;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] vote;
  logic       out_err;
  logic [2:0] excluded;
  logic [7:0] mis_cnt_a, mis_cnt_b, mis_cnt_c;

  int n_cmp;
  int n_bad;

  tmr_vote_monitor #(.WIDTH(8), .FAULT_LIMIT(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .c           (c),
    .clear_faults(clear_faults),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .vote        (vote),
    .out_err     (out_err),
    .excluded    (excluded),
    .mis_cnt_a   (mis_cnt_a),
    .mis_cnt_b   (mis_cnt_b),
    .mis_cnt_c   (mis_cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       xfer;
    logic       clr;
    logic [7:0] a, b, c;
    logic [7:0] vote;
    logic       err;
    logic       ov;
    logic [2:0] exc;
    logic [7:0] ma, mb, mc;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //          xfer clr  a      b      c      vote   err ov  exc     ma    mb    mc
    tbl[0]  = '{1'b1, 1'b0, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b1, 3'b000, 8'd0, 8'd0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 8'h0F, 8'h0F, 8'hFF, 8'h0F, 1'b0, 1'b1, 3'b000, 8'd0, 8'd0, 8'd1};
    tbl[2]  = '{1'b1, 1'b0, 8'h0F, 8'h0F, 8'hFF, 8'h0F, 1'b0, 1'b1, 3'b000, 8'd0, 8'd0, 8'd2};
    tbl[3]  = '{1'b1, 1'b0, 8'h0F, 8'h0F, 8'hFF, 8'h0F, 1'b0, 1'b1, 3'b000, 8'd0, 8'd0, 8'd3};
    tbl[4]  = '{1'b1, 1'b0, 8'h0F, 8'h0F, 8'hFF, 8'h0F, 1'b0, 1'b1, 3'b100, 8'd0, 8'd0, 8'd4};
    tbl[5]  = '{1'b1, 1'b0, 8'h01, 8'h02, 8'hFF, 8'h01, 1'b1, 1'b1, 3'b100, 8'd1, 8'd1, 8'd4};
    tbl[6]  = '{1'b1, 1'b1, 8'h03, 8'h07, 8'h00, 8'h03, 1'b1, 1'b1, 3'b000, 8'd0, 8'd0, 8'd0};
    tbl[7]  = '{1'b1, 1'b0, 8'h11, 8'h22, 8'h22, 8'h22, 1'b0, 1'b1, 3'b000, 8'd1, 8'd0, 8'd0};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h22, 1'b0, 1'b0, 3'b000, 8'd0, 8'd0, 8'd0};
    tbl[9]  = '{1'b1, 1'b0, 8'h5B, 8'h58, 8'h5A, 8'h5A, 1'b0, 1'b1, 3'b000, 8'd1, 8'd1, 8'd0};
    tbl[10] = '{1'b1, 1'b0, 8'h5B, 8'h58, 8'h5A, 8'h5A, 1'b0, 1'b1, 3'b000, 8'd2, 8'd2, 8'd0};
    tbl[11] = '{1'b1, 1'b0, 8'h5B, 8'h58, 8'h5A, 8'h5A, 1'b0, 1'b1, 3'b000, 8'd3, 8'd3, 8'd0};
    tbl[12] = '{1'b1, 1'b0, 8'h5B, 8'h58, 8'h5A, 8'h5A, 1'b0, 1'b1, 3'b001, 8'd4, 8'd4, 8'd0};
    tbl[13] = '{1'b1, 1'b0, 8'h77, 8'h10, 8'h10, 8'h10, 1'b0, 1'b1, 3'b001, 8'd4, 8'd4, 8'd0};
    tbl[14] = '{1'b1, 1'b0, 8'h77, 8'h10, 8'h11, 8'h10, 1'b1, 1'b1, 3'b001, 8'd4, 8'd5, 8'd1};

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    clear_faults = 1'b0;
    out_ready    = 1'b1;
    a            = 8'h00;
    b            = 8'h00;
    c            = 8'h00;

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_vote",      32'(vote),      32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_excluded",  32'(excluded),  32'd0);
    chk("rst_mis_a",     32'(mis_cnt_a), 32'd0);
    chk("rst_mis_b",     32'(mis_cnt_b), 32'd0);
    chk("rst_mis_c",     32'(mis_cnt_c), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in_valid     = tbl[i].xfer;
      clear_faults = tbl[i].clr;
      a            = tbl[i].a;
      b            = tbl[i].b;
      c            = tbl[i].c;
      out_ready    = 1'b1;
      @(posedge clk);
      #1;
      in_valid     = 1'b0;
      clear_faults = 1'b0;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("v%0d_vote", i),      32'(vote),      32'(tbl[i].vote));
      chk($sformatf("v%0d_out_err", i),   32'(out_err),   32'(tbl[i].err));
      chk($sformatf("v%0d_excluded", i),  32'(excluded),  32'(tbl[i].exc));
      chk($sformatf("v%0d_mis_a", i),     32'(mis_cnt_a), 32'(tbl[i].ma));
      chk($sformatf("v%0d_mis_b", i),     32'(mis_cnt_b), 32'(tbl[i].mb));
      chk($sformatf("v%0d_mis_c", i),     32'(mis_cnt_c), 32'(tbl[i].mc));
      if (i == 12) chk("tie_cons_b_cleared", 32'(dut.cons_q[1]), 32'd0);
    end

    // Backpressure: drain, clear faults, then hold a result with out_ready low.
    @(negedge clk);
    in_valid     = 1'b0;
    clear_faults = 1'b1;
    out_ready    = 1'b1;
    @(posedge clk);
    #1;
    clear_faults = 1'b0;
    chk("bp_drained", 32'(out_valid), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 8'hAA; b = 8'hAA; c = 8'hAA;
    @(posedge clk);
    #1;
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    chk("bp_first_vote",  32'(vote),      32'hAA);
    chk("bp_in_ready_lo", 32'(in_ready),  32'd0);
    a = 8'hBB; b = 8'hBB; c = 8'hBB;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d_vote", k),  32'(vote),      32'hAA);
      chk($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_ready", k), 32'(in_ready),  32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_hi", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("b2b_vote_bb", 32'(vote), 32'hBB);
    a = 8'hCC; b = 8'hCC; c = 8'hCC;
    @(posedge clk);
    #1;
    chk("b2b_vote_cc",  32'(vote),      32'hCC);
    chk("b2b_valid_cc", 32'(out_valid), 32'd1);
    a = 8'hDD; b = 8'hDD; c = 8'hDD;
    @(posedge clk);
    #1;
    chk("b2b_vote_dd", 32'(vote), 32'hDD);
    in_valid = 1'b0;

    // Asynchronous reset while a result is pending.
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'hAA; b = 8'hAA; c = 8'hAB;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_arst_valid", 32'(out_valid), 32'd1);
    chk("pre_arst_mis_c", 32'(mis_cnt_c), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_mis_c",     32'(mis_cnt_c), 32'd0);
    chk("arst_vote",      32'(vote),      32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
